alu_multicycle: RTL

// - Next-generation MIPS execute-stage ALU: registered, parametrised WIDTH, valid/ready handshake.
// - Single-cycle ops: arithmetic, logic, shift, compare, lui. Iterative mult/div (signed and unsigned) write HI/LO.
// - Adds signed overflow and divide-by-zero flags, plus mfhi/mflo.
// - Sits between the ID/EX register and the EX/MEM register; the hazard unit stalls the pipeline on in_ready=0.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_iter_muldiv.sv | 108 ++++++++++
 rtl/alu_multicycle.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// +------------------------------------------------------------------+
// | alu_pkg : op codes, FSM states and shift-amount helper for ALU    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_ADDU  = 5'd2,  OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,  OP_XOR   = 5'd5,  OP_NOR   = 5'd6,  OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,  OP_SLT   = 5'd9,  OP_MULT  = 5'd10, OP_DIV   = 5'd11,
    OP_SRA   = 5'd12, OP_OR    = 5'd13, OP_LUI   = 5'd14, OP_MFHI  = 5'd15,
    OP_MFLO  = 5'd16, OP_MULTU = 5'd17, OP_DIVU  = 5'd18, OP_SLTU  = 5'd19
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

  function automatic int alu_shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
// +------------------------------------------------------------------+
// | alu_iter_muldiv : one-bit-per-cycle shift-add multiply and        |
// | restoring divide on magnitudes, sign fix-up on the outputs. 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module alu_iter_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  localparam int CNT_W = alu_shamt_w(WIDTH);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_mb;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_prod;

  assign w_mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_mb};
  // Remainder stays below the divisor, so WIDTH+1 bits hold the trial sign.
  assign w_trial = {r_acc, r_q[WIDTH-1]} - {1'b0, r_mb};
  assign done    = r_busy && (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_mb    <= '0;
      r_a_raw <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= w_mag_a;
      r_mb    <= w_mag_b;
      r_a_raw <= a;
      r_div   <= is_div;
      r_neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= is_signed && a[WIDTH-1];
      r_div0  <= (b == '0);
    end else if (r_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (done) r_busy <= 1'b0;
      if (r_div) begin
        if (!w_trial[WIDTH]) begin
          r_acc <= w_trial[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
      end else if (r_q[0]) begin
        {r_acc, r_q} <= {w_sum, r_q[WIDTH-1:1]};
      end else begin
        {r_acc, r_q} <= {1'b0, r_acc, r_q[WIDTH-1:1]};
      end
    end
  end

  assign w_prod = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};

  always_comb begin
    hi_n = w_prod[2*WIDTH-1:WIDTH];
    lo_n = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_div0) begin
        hi_n = r_a_raw;
        lo_n = '1;
      end else begin
        hi_n = r_neg_r ? -r_acc : r_acc;
        lo_n = r_neg_q ? -r_q : r_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_multicycle.sv
// +------------------------------------------------------------------+
// | alu_multicycle : registered execute-stage ALU with iterative      |
// | mult/div into HI/LO and valid/ready handshake.  Rev 1.0           |
// +------------------------------------------------------------------+
`default_nettype none

module alu_multicycle import alu_pkg::*; #(
  parameter int WIDTH          = 32,
  parameter int CONTROL_LENGTH = 5,
  parameter int SHAMT_W        = alu_shamt_w(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CONTROL_LENGTH-1:0] control,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          alu_result,
  output logic                      zero,
  output logic                      overflow,
  output logic                      div_by_zero,
  output logic [WIDTH-1:0]          hi,
  output logic [WIDTH-1:0]          lo
);

  state_e           r_state, w_state_nxt;
  logic             r_dz;
  logic             w_accept, w_fin, w_done;
  logic [4:0]       w_op;
  logic             w_op_ext_zero, w_is_mul, w_is_div, w_is_signed, w_start;
  logic [WIDTH-1:0] w_sum, w_diff, w_result, w_hi_n, w_lo_n;
  logic             w_ovf;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_op          = control[4:0];
  assign w_op_ext_zero = (control >> 5) == '0;
  assign w_is_mul      = w_op_ext_zero && (w_op == OP_MULT || w_op == OP_MULTU);
  assign w_is_div      = w_op_ext_zero && (w_op == OP_DIV || w_op == OP_DIVU);
  assign w_is_signed   = (w_op == OP_MULT || w_op == OP_DIV);
  assign w_accept      = in_valid && in_ready;
  assign w_start       = w_accept && (w_is_mul || w_is_div);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .is_div    (w_is_div),
    .is_signed (w_is_signed),
    .a         (a),
    .b         (b),
    .done      (w_done),
    .hi_n      (w_hi_n),
    .lo_n      (w_lo_n)
  );

  assign w_sum   = a + b;
  assign w_diff  = a - b;
  assign w_shamt = a[SHAMT_W-1:0];

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    if (w_op_ext_zero) begin
      case (w_op)
        OP_ADD: begin
          w_result = w_sum;
          w_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          w_result = w_diff;
          w_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_ADDU: w_result = w_sum;
        OP_SUBU: w_result = w_diff;
        OP_AND:  w_result = a & b;
        OP_OR:   w_result = a | b;
        OP_XOR:  w_result = a ^ b;
        OP_NOR:  w_result = ~(a | b);
        OP_SLL:  w_result = b << w_shamt;
        OP_SRL:  w_result = b >> w_shamt;
        OP_SRA:  w_result = $signed(b) >>> w_shamt;
        OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, a < b};
        OP_LUI:  w_result = b << 16;
        OP_MFHI: w_result = hi;
        OP_MFLO: w_result = lo;
        default: w_result = '0;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = MUL;
        else if (w_accept && w_is_div) w_state_nxt = DIV;
      end
      MUL, DIV: if (w_done) w_state_nxt = FIN;
      FIN:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (r_state == IDLE);
    w_fin    = (r_state == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_result  <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      r_dz        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (w_start) r_dz <= w_is_div && (b == '0);
      if (w_fin) begin
        out_valid   <= 1'b1;
        alu_result  <= w_lo_n;
        zero        <= (w_lo_n == '0);
        overflow    <= 1'b0;
        div_by_zero <= r_dz;
        hi          <= w_hi_n;
        lo          <= w_lo_n;
      end else if (w_accept && !(w_is_mul || w_is_div)) begin
        out_valid   <= 1'b1;
        alu_result  <= w_result;
        zero        <= (w_result == '0);
        overflow    <= w_ovf;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
